// File: rtl/decode_cycle.sv
// -----------------------------------------------------------------------------
// decode_cycle
//   Instruction-decode stage for an RV32IM pipeline. It sits between the
//   IF/ID register and execute. The stage does four things:
//     - holds the architectural register file, with write-through on the
//       writeback port;
//     - decodes the control signals;
//     - builds the sign-extended immediate;
//     - registers the result into the ID/EX pipeline register.
//
//   Optional feature macro: RV32M_DECODE_EN
//     defined   : OP with funct7=0000001 decodes to the M-extension ALU ops
//     undefined : those encodings are flagged illegal
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   pc_in, instr_in        fetched PC / instruction from IF/ID
//   hold_in                freeze the ID/EX register (multi-cycle EX op)
//   bubble_in              load the ID/EX register with a NOP
//   wb_en, wb_rd, wb_data  register file writeback port
//   pc_out                 registered PC
//   rs1_data_out,
//   rs2_data_out           registered operands
//   imm_out                registered sign-extended immediate
//   rs1_out, rs2_out,
//   rd_out                 raw register index fields
//   alu_op_out             ALU operation code
//   alu_src_a_out          operand A select: 0=rs1, 1=PC
//   alu_src_b_out          operand B select: 0=rs2, 1=imm
//   funct3_out             branch condition / memory size
//   mem_read_out,
//   mem_write_out,
//   reg_write_out,
//   branch_out,
//   jump_out, jalr_out     control strobes
//   wb_sel_out             writeback select: 0=ALU, 1=mem, 2=PC+4
//   illegal_out            unrecognised encoding
// -----------------------------------------------------------------------------
module decode_cycle #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     pc_in,
    input  logic [31:0]     instr_in,
    input  logic            hold_in,
    input  logic            bubble_in,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [31:0]     pc_out,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [31:0]     imm_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [4:0]      alu_op_out,
    output logic            alu_src_a_out,
    output logic            alu_src_b_out,
    output logic [2:0]      funct3_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            reg_write_out,
    output logic            branch_out,
    output logic            jump_out,
    output logic            jalr_out,
    output logic [1:0]      wb_sel_out,
    output logic            illegal_out
);

    localparam int unsigned ALU_W = 5;

    localparam logic [ALU_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [ALU_W-1:0] ALU_SLL    = 5'd2;
    localparam logic [ALU_W-1:0] ALU_SLT    = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SLTU   = 5'd4;
    localparam logic [ALU_W-1:0] ALU_XOR    = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SRL    = 5'd6;
    localparam logic [ALU_W-1:0] ALU_SRA    = 5'd7;
    localparam logic [ALU_W-1:0] ALU_OR     = 5'd8;
    localparam logic [ALU_W-1:0] ALU_AND    = 5'd9;
    localparam logic [ALU_W-1:0] ALU_PASSB  = 5'd10;
`ifdef RV32M_DECODE_EN
    localparam logic [ALU_W-1:0] ALU_M_BASE = 5'd16;
`endif

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;

    assign opcode  = instr_in[6:0];
    assign rd_idx  = instr_in[11:7];
    assign funct3  = instr_in[14:12];
    assign rs1_idx = instr_in[19:15];
    assign rs2_idx = instr_in[24:20];
    assign funct7  = instr_in[31:25];

    // Immediate formats, all sign-extended from instr[31]
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                    instr_in[20], instr_in[30:21], 1'b0};

    // Register file; entry 0 is never written so it reads as zero
    logic [XLEN-1:0] regs [NREGS];
    logic            wb_fire;

    assign wb_fire = wb_en && (wb_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Operand read with same-cycle writeback forwarding
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        rs1_val = regs[rs1_idx];
        rs2_val = regs[rs2_idx];
        if (wb_fire && (wb_rd == rs1_idx)) begin
            rs1_val = wb_data;
        end
        if (wb_fire && (wb_rd == rs2_idx)) begin
            rs2_val = wb_data;
        end
    end

    // Control decode
    logic [31:0]      d_imm;
    logic [ALU_W-1:0] d_alu_op;
    logic             d_src_a;
    logic             d_src_b;
    logic             d_mem_read;
    logic             d_mem_write;
    logic             d_reg_write;
    logic             d_branch;
    logic             d_jump;
    logic             d_jalr;
    logic [1:0]       d_wb_sel;
    logic             d_illegal;
    logic [2:0]       d_funct3;

    always_comb begin
        d_imm       = '0;
        d_alu_op    = ALU_ADD;
        d_src_a     = 1'b0;
        d_src_b     = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_jalr      = 1'b0;
        d_wb_sel    = WB_ALU;
        d_illegal   = 1'b0;

        unique case (opcode)
            OPC_LUI: begin
                d_imm       = imm_u;
                d_alu_op    = ALU_PASSB;
                d_src_b     = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                d_imm       = imm_u;
                d_src_a     = 1'b1;
                d_src_b     = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_JAL: begin
                d_imm       = imm_j;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
                d_wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                d_imm       = imm_i;
                d_jalr      = 1'b1;
                d_src_b     = 1'b1;
                d_reg_write = 1'b1;
                d_wb_sel    = WB_PC4;
            end
            OPC_BRANCH: begin
                d_imm    = imm_b;
                d_branch = 1'b1;
                d_alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                d_imm       = imm_i;
                d_src_b     = 1'b1;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
                d_wb_sel    = WB_MEM;
            end
            OPC_STORE: begin
                d_imm       = imm_s;
                d_src_b     = 1'b1;
                d_mem_write = 1'b1;
            end
            OPC_OPIMM: begin
                d_imm       = imm_i;
                d_src_b     = 1'b1;
                d_reg_write = 1'b1;
                unique case (funct3)
                    3'b000:  d_alu_op = ALU_ADD;
                    3'b001:  d_alu_op = ALU_SLL;
                    3'b010:  d_alu_op = ALU_SLT;
                    3'b011:  d_alu_op = ALU_SLTU;
                    3'b100:  d_alu_op = ALU_XOR;
                    3'b101:  d_alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  d_alu_op = ALU_OR;
                    default: d_alu_op = ALU_AND;
                endcase
            end
            OPC_OP: begin
                d_reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    unique case (funct3)
                        3'b000:  d_alu_op = ALU_ADD;
                        3'b001:  d_alu_op = ALU_SLL;
                        3'b010:  d_alu_op = ALU_SLT;
                        3'b011:  d_alu_op = ALU_SLTU;
                        3'b100:  d_alu_op = ALU_XOR;
                        3'b101:  d_alu_op = ALU_SRL;
                        3'b110:  d_alu_op = ALU_OR;
                        default: d_alu_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    d_alu_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    d_alu_op = ALU_SRA;
`ifdef RV32M_DECODE_EN
                end else if (funct7 == 7'b0000001) begin
                    d_alu_op = ALU_M_BASE | ALU_W'(funct3);
`endif
                end else begin
                    d_reg_write = 1'b0;
                    d_illegal   = 1'b1;
                end
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Architectural no-ops in this pipeline
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase

        // Illegal encodings carry no funct3 so nothing downstream can act on it
        d_funct3 = d_illegal ? 3'b000 : funct3;
    end

    // ID/EX pipeline register: rst > hold > bubble > load
    always_ff @(posedge clk) begin
        if (rst || (bubble_in && !hold_in)) begin
            pc_out        <= '0;
            rs1_data_out  <= '0;
            rs2_data_out  <= '0;
            imm_out       <= '0;
            rs1_out       <= '0;
            rs2_out       <= '0;
            rd_out        <= '0;
            alu_op_out    <= '0;
            alu_src_a_out <= 1'b0;
            alu_src_b_out <= 1'b0;
            funct3_out    <= '0;
            mem_read_out  <= 1'b0;
            mem_write_out <= 1'b0;
            reg_write_out <= 1'b0;
            branch_out    <= 1'b0;
            jump_out      <= 1'b0;
            jalr_out      <= 1'b0;
            wb_sel_out    <= '0;
            illegal_out   <= 1'b0;
        end else if (!hold_in) begin
            pc_out        <= pc_in;
            rs1_data_out  <= rs1_val;
            rs2_data_out  <= rs2_val;
            imm_out       <= d_imm;
            rs1_out       <= rs1_idx;
            rs2_out       <= rs2_idx;
            rd_out        <= rd_idx;
            alu_op_out    <= d_alu_op;
            alu_src_a_out <= d_src_a;
            alu_src_b_out <= d_src_b;
            funct3_out    <= d_funct3;
            mem_read_out  <= d_mem_read;
            mem_write_out <= d_mem_write;
            reg_write_out <= d_reg_write;
            branch_out    <= d_branch;
            jump_out      <= d_jump;
            jalr_out      <= d_jalr;
            wb_sel_out    <= d_wb_sel;
            illegal_out   <= d_illegal;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// -----------------------------------------------------------------------------
// tb_decode_cycle
//   Directed, self-checking bench for decode_cycle. Each task drives one
//   scenario and checks the outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        hold_in;
    logic        bubble_in;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] pc_out;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic [31:0] imm_out;
    logic [4:0]  rs1_out;
    logic [4:0]  rs2_out;
    logic [4:0]  rd_out;
    logic [4:0]  alu_op_out;
    logic        alu_src_a_out;
    logic        alu_src_b_out;
    logic [2:0]  funct3_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        reg_write_out;
    logic        branch_out;
    logic        jump_out;
    logic        jalr_out;
    logic [1:0]  wb_sel_out;
    logic        illegal_out;

    int compared;
    int mismatched;

    logic [161:0] all_out;
    assign all_out = {pc_out, rs1_data_out, rs2_data_out, imm_out,
                      rs1_out, rs2_out, rd_out, alu_op_out,
                      alu_src_a_out, alu_src_b_out, funct3_out,
                      mem_read_out, mem_write_out, reg_write_out,
                      branch_out, jump_out, jalr_out, wb_sel_out, illegal_out};

    decode_cycle dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .instr_in      (instr_in),
        .hold_in       (hold_in),
        .bubble_in     (bubble_in),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .pc_out        (pc_out),
        .rs1_data_out  (rs1_data_out),
        .rs2_data_out  (rs2_data_out),
        .imm_out       (imm_out),
        .rs1_out       (rs1_out),
        .rs2_out       (rs2_out),
        .rd_out        (rd_out),
        .alu_op_out    (alu_op_out),
        .alu_src_a_out (alu_src_a_out),
        .alu_src_b_out (alu_src_b_out),
        .funct3_out    (funct3_out),
        .mem_read_out  (mem_read_out),
        .mem_write_out (mem_write_out),
        .reg_write_out (reg_write_out),
        .branch_out    (branch_out),
        .jump_out      (jump_out),
        .jalr_out      (jalr_out),
        .wb_sel_out    (wb_sel_out),
        .illegal_out   (illegal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        // Write x5, keep a live instruction in flight, then reset over it
        pc_in    = 32'h0000_0100;
        instr_in = 32'h0052_8333;
        wb_en    = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hAAAA_5555;
        tick();
        wb_en = 1'b0;
        do_reset();
        compared++;
        if (all_out !== 162'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h, want 0", all_out);
        end
        // x5 was cleared by reset
        instr_in = 32'h0052_8333;
        tick();
        compared++;
        if (rs1_data_out !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_regfile: rs1_data_out got %h, want 0", rs1_data_out);
        end
        instr_in = 32'h0000_0033;
        tick();
        compared++;
        if (rs1_data_out !== 32'h0 || rs2_data_out !== 32'h0 || reg_write_out !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_add_x0: rs1d %h rs2d %h rw %b, want 0 0 1",
                     rs1_data_out, rs2_data_out, reg_write_out);
        end
    endtask

    task automatic test_regfile();
        // Write x5 one cycle ahead of the read
        instr_in = 32'h0000_0013;
        wb_en    = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hDEAD_BEEF;
        tick();
        wb_en    = 1'b0;
        pc_in    = 32'h0000_0200;
        instr_in = 32'h0052_8333;
        tick();
        compared++;
        if (rs1_data_out !== 32'hDEAD_BEEF || rs2_data_out !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL wr_then_rd_data: rs1d %h rs2d %h, want deadbeef",
                     rs1_data_out, rs2_data_out);
        end
        compared++;
        if (alu_op_out !== 5'd0 || rd_out !== 5'd6 || reg_write_out !== 1'b1 ||
            rs1_out !== 5'd5 || rs2_out !== 5'd5 || pc_out !== 32'h0000_0200 ||
            imm_out !== 32'h0 || illegal_out !== 1'b0) begin
            mismatched++;
            $display("FAIL wr_then_rd_ctrl: alu %0d rd %0d rw %b rs1 %0d rs2 %0d pc %h imm %h ill %b",
                     alu_op_out, rd_out, reg_write_out, rs1_out, rs2_out, pc_out, imm_out, illegal_out);
        end
        // Writeback in the same cycle as decode must bypass
        wb_en   = 1'b1;
        wb_rd   = 5'd5;
        wb_data = 32'h1234_5678;
        tick();
        wb_en = 1'b0;
        compared++;
        if (rs1_data_out !== 32'h1234_5678 || rs2_data_out !== 32'h1234_5678 ||
            alu_op_out !== 5'd0 || rd_out !== 5'd6 || reg_write_out !== 1'b1) begin
            mismatched++;
            $display("FAIL bypass: rs1d %h rs2d %h alu %0d rd %0d rw %b, want 12345678 12345678 0 6 1",
                     rs1_data_out, rs2_data_out, alu_op_out, rd_out, reg_write_out);
        end
        tick();
        compared++;
        if (rs1_data_out !== 32'h1234_5678) begin
            mismatched++;
            $display("FAIL bypass_committed: rs1d %h, want 12345678", rs1_data_out);
        end
        // x0 is never written and never bypassed
        instr_in = 32'h0000_0033;
        wb_en    = 1'b1;
        wb_rd    = 5'd0;
        wb_data  = 32'h0000_1234;
        tick();
        wb_en = 1'b0;
        compared++;
        if (rs1_data_out !== 32'h0 || rs2_data_out !== 32'h0) begin
            mismatched++;
            $display("FAIL x0_bypass: rs1d %h rs2d %h, want 0", rs1_data_out, rs2_data_out);
        end
        tick();
        compared++;
        if (rs1_data_out !== 32'h0) begin
            mismatched++;
            $display("FAIL x0_protect: rs1d %h, want 0", rs1_data_out);
        end
    endtask

    task automatic test_decode();
        // beq x1,x2,-8
        instr_in = 32'hFE20_8CE3;
        tick();
        compared++;
        if (imm_out !== 32'hFFFF_FFF8 || branch_out !== 1'b1 || alu_op_out !== 5'd1 ||
            funct3_out !== 3'd0 || reg_write_out !== 1'b0 || rs1_out !== 5'd1 || rs2_out !== 5'd2) begin
            mismatched++;
            $display("FAIL branch: imm %h br %b alu %0d f3 %0d rw %b rs1 %0d rs2 %0d",
                     imm_out, branch_out, alu_op_out, funct3_out, reg_write_out, rs1_out, rs2_out);
        end
        // lui x1,0x12345
        instr_in = 32'h1234_50B7;
        tick();
        compared++;
        if (imm_out !== 32'h1234_5000 || alu_op_out !== 5'd10 || alu_src_b_out !== 1'b1 ||
            reg_write_out !== 1'b1 || wb_sel_out !== 2'd0 || rd_out !== 5'd1) begin
            mismatched++;
            $display("FAIL lui: imm %h alu %0d srcb %b rw %b wbs %0d rd %0d",
                     imm_out, alu_op_out, alu_src_b_out, reg_write_out, wb_sel_out, rd_out);
        end
        // lw x3,-4(x2)
        instr_in = 32'hFFC1_2183;
        tick();
        compared++;
        if (imm_out !== 32'hFFFF_FFFC || mem_read_out !== 1'b1 || wb_sel_out !== 2'd1 ||
            funct3_out !== 3'd2 || alu_src_b_out !== 1'b1 || alu_op_out !== 5'd0 || reg_write_out !== 1'b1) begin
            mismatched++;
            $display("FAIL load: imm %h mr %b wbs %0d f3 %0d srcb %b alu %0d rw %b",
                     imm_out, mem_read_out, wb_sel_out, funct3_out, alu_src_b_out, alu_op_out, reg_write_out);
        end
        // srai x1,x1,3
        instr_in = 32'h4030_D093;
        tick();
        compared++;
        if (alu_op_out !== 5'd7 || alu_src_b_out !== 1'b1 || reg_write_out !== 1'b1) begin
            mismatched++;
            $display("FAIL srai: alu %0d srcb %b rw %b, want 7 1 1",
                     alu_op_out, alu_src_b_out, reg_write_out);
        end
        // jal x1,+8
        instr_in = 32'h0080_00EF;
        tick();
        compared++;
        if (imm_out !== 32'h0000_0008 || jump_out !== 1'b1 || wb_sel_out !== 2'd2 || reg_write_out !== 1'b1) begin
            mismatched++;
            $display("FAIL jal: imm %h jump %b wbs %0d rw %b", imm_out, jump_out, wb_sel_out, reg_write_out);
        end
        // Unknown opcode
        instr_in = 32'hFFFF_FFFF;
        tick();
        compared++;
        if (illegal_out !== 1'b1 || reg_write_out !== 1'b0 || alu_op_out !== 5'd0 ||
            mem_read_out !== 1'b0 || mem_write_out !== 1'b0 || branch_out !== 1'b0 || jump_out !== 1'b0) begin
            mismatched++;
            $display("FAIL illegal_opc: ill %b rw %b alu %0d mr %b mw %b br %b j %b",
                     illegal_out, reg_write_out, alu_op_out, mem_read_out, mem_write_out, branch_out, jump_out);
        end
    endtask

    task automatic test_hold_bubble();
        do_reset();
        pc_in    = 32'h0000_0300;
        instr_in = 32'hFE20_8CE3;
        tick();
        // Hold wins over bubble; writeback to x1 still lands
        hold_in   = 1'b1;
        bubble_in = 1'b1;
        pc_in     = 32'h0000_0304;
        instr_in  = 32'h1234_50B7;
        wb_en     = 1'b1;
        wb_rd     = 5'd1;
        wb_data   = 32'h0000_0055;
        tick();
        wb_en = 1'b0;
        tick();
        compared++;
        if (pc_out !== 32'h0000_0300 || imm_out !== 32'hFFFF_FFF8 || branch_out !== 1'b1 ||
            alu_op_out !== 5'd1 || rs1_out !== 5'd1 || rs1_data_out !== 32'h0 || alu_src_b_out !== 1'b0) begin
            mismatched++;
            $display("FAIL hold: pc %h imm %h br %b alu %0d rs1 %0d rs1d %h srcb %b",
                     pc_out, imm_out, branch_out, alu_op_out, rs1_out, rs1_data_out, alu_src_b_out);
        end
        hold_in = 1'b0;
        tick();
        compared++;
        if (all_out !== 162'd0) begin
            mismatched++;
            $display("FAIL bubble: got %h, want 0", all_out);
        end
        bubble_in = 1'b0;
        instr_in  = 32'hFE20_8CE3;
        tick();
        compared++;
        if (rs1_data_out !== 32'h0000_0055 || rs2_data_out !== 32'h0) begin
            mismatched++;
            $display("FAIL wb_during_hold: rs1d %h rs2d %h, want 55 0", rs1_data_out, rs2_data_out);
        end
    endtask

    task automatic test_mext();
        // mul x3,x1,x2
        instr_in = 32'h0220_81B3;
        tick();
        compared++;
`ifdef RV32M_DECODE_EN
        if (alu_op_out !== 5'd16 || reg_write_out !== 1'b1 || illegal_out !== 1'b0 || rd_out !== 5'd3) begin
            mismatched++;
            $display("FAIL mul_en: alu %0d rw %b ill %b rd %0d, want 16 1 0 3",
                     alu_op_out, reg_write_out, illegal_out, rd_out);
        end
`else
        if (illegal_out !== 1'b1 || reg_write_out !== 1'b0 || alu_op_out !== 5'd0 || rd_out !== 5'd3) begin
            mismatched++;
            $display("FAIL mul_dis: ill %b rw %b alu %0d rd %0d, want 1 0 0 3",
                     illegal_out, reg_write_out, alu_op_out, rd_out);
        end
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        pc_in      = '0;
        instr_in   = '0;
        hold_in    = 1'b0;
        bubble_in  = 1'b0;
        wb_en      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        tick();
        rst = 1'b0;

        test_reset();
        test_regfile();
        test_decode();
        test_hold_bubble();
        test_mext();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
